// File: rtl/ram_sum_ctrl_pkg.sv
// Shared types and constants for the RAM sum controller.
// State encoding and default width helpers.
package ram_sum_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int SUM_WIDTH =
    DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_sum_ctrl.sv
// Reads a run of RAM words, accumulates sum and max,
// writes the truncated sum back and pulses done.
module ram_sum_ctrl
  import ram_sum_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic                  ovf
);

  localparam int SW = DATA_WIDTH + ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         issued;
  logic                  v1;
  logic                  v2;
  logic [SW-1:0]         acc_sum;
  logic [DATA_WIDTH-1:0] acc_max;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  // Candidate accumulator values for the word now on ram_q.
  always_comb begin
    acc_sum  = sum + SW'(ram_q);
    acc_max  = (ram_q > max_val) ? ram_q : max_val;
    nxt_addr = base_q + issued[ADDR_WIDTH-1:0];
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      base_q         <= '0;
      dst_q          <= '0;
      cnt_q          <= '0;
      issued         <= '0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      ram_read_addr  <= '0;
      ram_write_addr <= '0;
      ram_data       <= '0;
      ram_we         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sum            <= '0;
      max_val        <= '0;
      ovf            <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_q        <= base_addr;
            cnt_q         <= count;
            dst_q         <= dst_addr;
            sum           <= '0;
            max_val       <= '0;
            ovf           <= 1'b0;
            ram_read_addr <= base_addr;
            issued        <= CW'(1);
            busy          <= 1'b1;
            v2            <= 1'b0;
            if (count == '0) begin
              v1             <= 1'b0;
              ram_we         <= 1'b1;
              ram_write_addr <= dst_addr;
              ram_data       <= '0;
              state          <= S_WRITE;
            end else begin
              v1    <= 1'b1;
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          v2 <= v1;
          if (issued < cnt_q) begin
            ram_read_addr <= nxt_addr;
            issued        <= issued + CW'(1);
            v1            <= 1'b1;
          end else begin
            v1 <= 1'b0;
          end
          if (v2) begin
            sum     <= acc_sum;
            max_val <= acc_max;
          end
          // Last in-flight word retires: hand off to write.
          if (v2 && !v1) begin
            ram_we         <= 1'b1;
            ram_write_addr <= dst_q;
            ram_data       <= acc_sum[DATA_WIDTH-1:0];
            ovf            <= |acc_sum[SW-1:DATA_WIDTH];
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          ram_we <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
